// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic                  wre;
    logic                  is_load;
  } sb_entry_t;

  // An in-flight writer hits a source only when that source is actually read.
  function automatic logic entry_hits(input sb_entry_t e, input logic [REG_ADDR_W-1:0] src,
                                      input logic uses);
    return e.valid && e.wre && uses && (e.dst == src);
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - EX/MEM/WB destination scoreboard with per-source match vectors
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  sb_entry_t             id_entry,
  input  logic [REG_ADDR_W-1:0] src_a,
  input  logic                  uses_a,
  input  logic [REG_ADDR_W-1:0] src_b,
  input  logic                  uses_b,
  output logic [2:0]            match_a,
  output logic [2:0]            match_b,
  output logic                  ex_load
);

  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t wb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= advance ? id_entry : '0;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Bit 0 is the youngest stage (EX), bit 2 the oldest (WB).
  always_comb begin
    match_a = {entry_hits(wb_q, src_a, uses_a), entry_hits(mem_q, src_a, uses_a),
               entry_hits(ex_q, src_a, uses_a)};
    match_b = {entry_hits(wb_q, src_b, uses_b), entry_hits(mem_q, src_b, uses_b),
               entry_hits(ex_q, src_b, uses_b)};
  end

  assign ex_load = ex_q.valid & ex_q.is_load;

  logic unused_wb_load;
  assign unused_wb_load = wb_q.is_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencing for the 5-stage pipe; PIPE_FORWARDING_EN adds operand forwarding
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src_a,
  input  logic [REG_ADDR_W-1:0] id_src_b,
  input  logic                  id_uses_a,
  input  logic                  id_uses_b,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_wre,
  input  logic                  id_is_load,
  input  logic                  jump_taken,
  output logic                  pc_en,
  output logic                  fd_en,
  output logic                  fd_flush,
  output logic                  de_bubble,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [15:0]           stall_cycles
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] flush_cnt_q;
  logic [1:0] flush_cnt_d;
  logic [2:0] match_a;
  logic [2:0] match_b;
  logic       ex_load;
  logic       hazard_raw;
  logic       hazard;
  logic       stall_now;
  logic       advance;
  sb_entry_t  id_entry;

  assign id_entry = {id_valid, id_dst, id_wre, id_is_load};
  assign advance  = ~de_bubble;

  pipe_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .advance  (advance),
    .id_entry (id_entry),
    .src_a    (id_src_a),
    .uses_a   (id_uses_a),
    .src_b    (id_src_b),
    .uses_b   (id_uses_b),
    .match_a  (match_a),
    .match_b  (match_b),
    .ex_load  (ex_load)
  );

`ifdef PIPE_FORWARDING_EN
  assign hazard_raw = ex_load & (match_a[0] | match_b[0]);
`else
  assign hazard_raw = (|match_a) | (|match_b);
`endif

  assign hazard = reset & id_valid & hazard_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The jump cycle itself is the first flush cycle, so FLUSH lasts FLUSH_CYCLES-1 cycles.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      FLUSH: begin
        if (flush_cnt_q >= 2'(FLUSH_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      default: begin
        if (jump_taken) begin
          state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          flush_cnt_d = 2'd1;
        end else if (hazard) begin
          state_d = STALL;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_comb begin
    pc_en     = 1'b0;
    fd_en     = 1'b0;
    fd_flush  = 1'b1;
    de_bubble = 1'b1;
    stall_now = 1'b0;
    if (reset) begin
      if (state_q == FLUSH || jump_taken) begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        fd_flush  = 1'b1;
        de_bubble = 1'b1;
      end else if (hazard) begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        fd_flush  = 1'b0;
        de_bubble = 1'b1;
        stall_now = 1'b1;
      end else begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 16'd0;
    end else if (stall_now && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

`ifdef PIPE_FORWARDING_EN
  fwd_sel_e fwd_a_q;
  fwd_sel_e fwd_b_q;

  // Youngest producer wins: EX match means the value sits in MEM next cycle.
  function automatic fwd_sel_e fwd_pick(input logic [2:0] m);
    if (m[0]) return FWD_MEM;
    if (m[1]) return FWD_WB;
    return FWD_RF;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (advance && id_valid) begin
      fwd_a_q <= fwd_pick(match_a);
      fwd_b_q <= fwd_pick(match_b);
    end else begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  logic unused_wb_match;
  assign unused_wb_match = match_a[2] | match_b[2];
`else
  assign fwd_a_sel = 2'd0;
  assign fwd_b_sel = 2'd0;

  logic unused_ex_load;
  assign unused_ex_load = ex_load;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid = 1'b0;
  logic [3:0]  id_src_a = '0;
  logic [3:0]  id_src_b = '0;
  logic        id_uses_a = 1'b0;
  logic        id_uses_b = 1'b0;
  logic [3:0]  id_dst = '0;
  logic        id_wre = 1'b0;
  logic        id_is_load = 1'b0;
  logic        jump_taken = 1'b0;
  logic        pc_en;
  logic        fd_en;
  logic        fd_flush;
  logic        de_bubble;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [15:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_src_a     (id_src_a),
    .id_src_b     (id_src_b),
    .id_uses_a    (id_uses_a),
    .id_uses_b    (id_uses_b),
    .id_dst       (id_dst),
    .id_wre       (id_wre),
    .id_is_load   (id_is_load),
    .jump_taken   (jump_taken),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .fd_flush     (fd_flush),
    .de_bubble    (de_bubble),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_cycles (stall_cycles)
  );

  // Reference model: per-register issue cycle of the youngest writer.
  int         m_cyc;
  int         m_last_wr[16];
  bit         m_last_ld[16];
  int         m_flush_rem;
  int         m_stall;
  logic [1:0] m_fa;
  logic [1:0] m_fb;

  function automatic void model_reset();
    m_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      m_last_wr[i] = -100;
      m_last_ld[i] = 1'b0;
    end
    m_flush_rem = 0;
    m_stall = 0;
    m_fa = 2'd0;
    m_fb = 2'd0;
  endfunction

  function automatic bit m_src_hazard(input logic [3:0] s, input logic u);
    int d;
    d = m_cyc - m_last_wr[s];
    if (!u || !id_valid) return 1'b0;
`ifdef PIPE_FORWARDING_EN
    return (d == 1) && m_last_ld[s];
`else
    return (d >= 1) && (d <= 3);
`endif
  endfunction

  function automatic logic [1:0] m_src_fwd(input logic [3:0] s, input logic u);
`ifdef PIPE_FORWARDING_EN
    int d;
    d = m_cyc - m_last_wr[s];
    if (!u) return 2'd0;
    if (d == 1) return 2'd1;
    if (d == 2) return 2'd2;
    return 2'd0;
`else
    return (s == 4'd0 && u && 1'b0) ? 2'd3 : 2'd0;
`endif
  endfunction

  // 0 = run, 1 = stall, 2 = flush
  function automatic int m_mode();
    if (m_flush_rem > 0 || jump_taken) return 2;
    if (m_src_hazard(id_src_a, id_uses_a) || m_src_hazard(id_src_b, id_uses_b)) return 1;
    return 0;
  endfunction

  function automatic void model_tick(input int mode);
    m_fa = 2'd0;
    m_fb = 2'd0;
    if (mode == 2) begin
      if (m_flush_rem > 0) m_flush_rem--;
      else m_flush_rem = FC - 1;
    end else if (mode == 1) begin
      if (m_stall < 65535) m_stall++;
    end else if (id_valid) begin
      m_fa = m_src_fwd(id_src_a, id_uses_a);
      m_fb = m_src_fwd(id_src_b, id_uses_b);
      if (id_wre) begin
        m_last_wr[id_dst] = m_cyc;
        m_last_ld[id_dst] = id_is_load;
      end
    end
    m_cyc++;
  endfunction

  function automatic int exp_stalls(input int d, input bit ld);
`ifdef PIPE_FORWARDING_EN
    return (ld && d == 1) ? 1 : 0;
`else
    return (ld && d == 0) ? -1 : 4 - d;
`endif
  endfunction

  function automatic logic [1:0] exp_sel(input int d);
`ifdef PIPE_FORWARDING_EN
    return (d == 1) ? 2'd1 : (d == 2) ? 2'd2 : 2'd0;
`else
    return (d < 0) ? 2'd3 : 2'd0;
`endif
  endfunction

  task automatic set_idle();
    id_valid = 1'b0;
    id_src_a = '0;
    id_src_b = '0;
    id_uses_a = 1'b0;
    id_uses_b = 1'b0;
    id_dst = '0;
    id_wre = 1'b0;
    id_is_load = 1'b0;
    jump_taken = 1'b0;
  endtask

  task automatic set_instr(input logic [3:0] dst, input logic wre, input logic ld,
                           input logic [3:0] sa, input logic ua,
                           input logic [3:0] sb, input logic ub);
    id_valid = 1'b1;
    id_dst = dst;
    id_wre = wre;
    id_is_load = ld;
    id_src_a = sa;
    id_uses_a = ua;
    id_src_b = sb;
    id_uses_b = ub;
    jump_taken = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_idle();
    jump_taken = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({pc_en, fd_en, fd_flush, de_bubble} !== 4'b0011) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0011", {pc_en, fd_en, fd_flush, de_bubble});
    end
    vectors++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_fwd got %b want 0000", {fwd_a_sel, fwd_b_sel});
    end
    vectors++;
    if (stall_cycles !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    jump_taken = 1'b0;
    @(negedge clk);
    vectors++;
    if ({pc_en, fd_en, fd_flush, de_bubble} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_release_run got %b want 1100", {pc_en, fd_en, fd_flush, de_bubble});
    end
  endtask

  // Producer writes r(3) (or r5 as a load), consumer reads it d instructions later.
  task automatic test_raw(input int d, input bit ld, input bit on_b);
    int n;
    logic [3:0] r;
    logic [1:0] sel;
    r = ld ? 4'd5 : 4'd3;
    do_reset();
    set_instr(r, 1'b1, ld, 4'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();
    for (int k = 1; k < d; k++) begin
      set_instr(4'(8 + k), 1'b1, 1'b0, 4'd12, 1'b1, 4'd13, 1'b0);
      next_cycle();
    end
    if (on_b) set_instr(4'd6, 1'b1, 1'b0, 4'd7, 1'b0, r, 1'b1);
    else      set_instr(4'd6, 1'b1, 1'b0, r, 1'b1, 4'd7, 1'b0);
    n = 0;
    @(negedge clk);
    while (pc_en === 1'b0 && n < 8) begin
      n++;
      vectors++;
      if ({fd_en, de_bubble} !== 2'b01) begin
        miscompares++;
        $display("FAIL raw_d%0d_stall_ctrl got %b want 01", d, {fd_en, de_bubble});
      end
      next_cycle();
      @(negedge clk);
    end
    vectors++;
    if (n !== exp_stalls(d, ld)) begin
      miscompares++;
      $display("FAIL raw_d%0d_ld%0d_stalls got %0d want %0d", d, ld, n, exp_stalls(d, ld));
    end
    vectors++;
    if (stall_cycles !== 16'(exp_stalls(d, ld))) begin
      miscompares++;
      $display("FAIL raw_d%0d_ld%0d_stall_cycles got %0d want %0d", d, ld, stall_cycles,
               exp_stalls(d, ld));
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    sel = ld ? exp_sel(2) : exp_sel(d);
    vectors++;
    if ((on_b ? fwd_b_sel : fwd_a_sel) !== sel) begin
      miscompares++;
      $display("FAIL raw_d%0d_ld%0d_fwd got %0d want %0d", d, ld,
               on_b ? fwd_b_sel : fwd_a_sel, sel);
    end
    vectors++;
    if ((on_b ? fwd_a_sel : fwd_b_sel) !== 2'd0) begin
      miscompares++;
      $display("FAIL raw_d%0d_other_fwd got %0d want 0", d, on_b ? fwd_a_sel : fwd_b_sel);
    end
  endtask

  task automatic test_jump_over_hazard();
    do_reset();
    set_instr(4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();
    set_instr(4'd6, 1'b1, 1'b0, 4'd3, 1'b1, 4'd7, 1'b0);
    jump_taken = 1'b1;
    @(negedge clk);
    vectors++;
    if ({pc_en, fd_en, fd_flush, de_bubble} !== 4'b1111) begin
      miscompares++;
      $display("FAIL jump_c1 got %b want 1111", {pc_en, fd_en, fd_flush, de_bubble});
    end
    next_cycle();
    set_idle();
    jump_taken = 1'b1;
    @(negedge clk);
    vectors++;
    if ({pc_en, fd_en, fd_flush, de_bubble} !== 4'b1111) begin
      miscompares++;
      $display("FAIL jump_c2 got %b want 1111", {pc_en, fd_en, fd_flush, de_bubble});
    end
    next_cycle();
    jump_taken = 1'b0;
    @(negedge clk);
    vectors++;
    if ({pc_en, fd_en, fd_flush, de_bubble} !== 4'b1100) begin
      miscompares++;
      $display("FAIL jump_c3_run got %b want 1100", {pc_en, fd_en, fd_flush, de_bubble});
    end
    vectors++;
    if (stall_cycles !== 16'd0) begin
      miscompares++;
      $display("FAIL jump_stall_cycles got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_instr(4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();
    set_instr(4'd6, 1'b1, 1'b0, 4'd3, 1'b1, 4'd7, 1'b0);
    next_cycle();
    reset = 1'b0;
    #1;
    vectors++;
    if ({pc_en, fd_en, fd_flush, de_bubble} !== 4'b0011) begin
      miscompares++;
      $display("FAIL midreset_ctrl got %b want 0011", {pc_en, fd_en, fd_flush, de_bubble});
    end
    vectors++;
    if (stall_cycles !== 16'd0 || {fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_regs got %0d/%b want 0/0000", stall_cycles, {fwd_a_sel, fwd_b_sel});
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({pc_en, fd_en, fd_flush, de_bubble} !== 4'b1100) begin
      miscompares++;
      $display("FAIL midreset_noresume got %b want 1100", {pc_en, fd_en, fd_flush, de_bubble});
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    vectors++;
    if (fwd_a_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL midreset_fwd got %0d want 0", fwd_a_sel);
    end
  endtask

  task automatic test_uses_flag();
    do_reset();
    set_instr(4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    next_cycle();
    set_instr(4'd6, 1'b1, 1'b0, 4'd3, 1'b0, 4'd7, 1'b1);
    @(negedge clk);
    vectors++;
    if ({pc_en, fd_en, fd_flush, de_bubble} !== 4'b1100) begin
      miscompares++;
      $display("FAIL uses_flag_ctrl got %b want 1100", {pc_en, fd_en, fd_flush, de_bubble});
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    vectors++;
    if (fwd_a_sel !== 2'd0 || stall_cycles !== 16'd0) begin
      miscompares++;
      $display("FAIL uses_flag_fwd got %0d/%0d want 0/0", fwd_a_sel, stall_cycles);
    end
  endtask

  task automatic test_random();
    int mode;
    bit hold;
    logic [3:0] exp_ctrl;
    hold = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        if ($urandom_range(0, 7) == 0) begin
          set_idle();
        end else begin
          set_instr(4'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end
      end
      jump_taken = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      mode = m_mode();
      exp_ctrl = (mode == 2) ? 4'b1111 : (mode == 1) ? 4'b0001 : 4'b1100;
      vectors++;
      if ({pc_en, fd_en, fd_flush, de_bubble} !== exp_ctrl) begin
        miscompares++;
        $display("FAIL rand_ctrl cyc %0d got %b want %b", i, {pc_en, fd_en, fd_flush, de_bubble},
                 exp_ctrl);
      end
      vectors++;
      if (fwd_a_sel !== m_fa || fwd_b_sel !== m_fb) begin
        miscompares++;
        $display("FAIL rand_fwd cyc %0d got %0d/%0d want %0d/%0d", i, fwd_a_sel, fwd_b_sel,
                 m_fa, m_fb);
      end
      vectors++;
      if (stall_cycles !== 16'(m_stall)) begin
        miscompares++;
        $display("FAIL rand_stall_cycles cyc %0d got %0d want %0d", i, stall_cycles, m_stall);
      end
      hold = (mode == 1);
      model_tick(mode);
      next_cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_raw(1, 1'b0, 1'b0);
    test_raw(2, 1'b0, 1'b0);
    test_raw(3, 1'b0, 1'b1);
    test_raw(1, 1'b1, 1'b1);
    test_jump_over_hazard();
    test_reset_mid_stall();
    test_uses_flag();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and flow controller for the 16-bit, five-stage pipeline. It sequences the PC register, the fetch/decode register and the decode/execute register. It tracks in-flight destination registers in a scoreboard, stalls fetch/decode on read-after-write hazards, and flushes the front end on a taken jump. With forwarding compiled in, it also drives the execute-stage operand forwarding selects.

## Interface
- REG_ADDR_W, 4, register address width (instruction fields [3:0], [7:4], [11:8])
- FLUSH_CYCLES, 2, cycles the front end is flushed after a taken jump (the synchronous ROM adds one stale fetch); legal 1..3
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_src_a / id_src_b  in  REG_ADDR_W  decode source register addresses
- id_uses_a / id_uses_b  in  1  instruction actually reads that source
- id_dst  in  REG_ADDR_W  decode destination register
- id_wre  in  1  decoded instruction writes the register file
- id_is_load  in  1  decoded instruction is a memory load
- jump_taken  in  1  execute stage redirects the PC (drives select_next_PC)
- pc_en  out  1  PC register load enable
- fd_en  out  1  fetch/decode register load enable
- fd_flush  out  1  load NOP into fetch/decode register
- de_bubble  out  1  load NOP into decode/execute register
- fwd_a_sel / fwd_b_sel  out  2  execute operand source: 0 regfile, 1 memory-stage ALU result, 2 writeback data
- stall_cycles  out  16  saturating count of stall cycles since reset

## Operation
- Scoreboard entries for EX, MEM and WB each hold {valid, dst, wre, is_load}. The entries shift every cycle: WB<=MEM, MEM<=EX. EX takes the decode entry when it advances; it takes an empty entry on stall or flush.
- A match means: entry valid, entry wre=1, entry dst equals a source with its uses flag=1. All 16 registers are tracked; r0 gets no special treatment.
- Hazard without forwarding: a match in EX, MEM or WB. The register file is written at the clock edge and has no write-through.
- Hazard with forwarding: a match in EX where the EX entry has is_load=1. This is the load-use case.
- FSM states: RUN, STALL, FLUSH.
  - RUN to STALL: on a hazard with jump_taken=0.
  - STALL to RUN: when the hazard clears.
  - Any state to FLUSH: on jump_taken. Jump has priority over a hazard; the pending stall is abandoned.
  - FLUSH to RUN: after FLUSH_CYCLES total cycles. The jump_taken cycle counts as the first.
  - jump_taken during FLUSH is ignored.
- Outputs:
  - RUN: pc_en=1, fd_en=1, fd_flush=0, de_bubble=0.
  - STALL: pc_en=0, fd_en=0, de_bubble=1.
  - FLUSH: pc_en=1, fd_en=1, fd_flush=1, de_bubble=1.
- Outputs are combinational from the current hazard, the state and jump_taken, so a stall takes effect in the same cycle the hazard appears.
- stall_cycles increments each cycle STALL is asserted and saturates at 16'hFFFF.

## Timing
- While reset is low:
  - pc_en=0, fd_en=0, fd_flush=1, de_bubble=1
  - fwd sels=0, stall_cycles=0
  - scoreboard cleared, state=RUN
- RUN state takes effect in the first cycle after reset deasserts.
- A hazard costs the following stall cycles:
  - without forwarding: 3 for a distance-1 producer, 2 for distance-2, 1 for distance-3
  - with forwarding: 1 for load-use only
- Taken jump: fd_flush and de_bubble are high for exactly FLUSH_CYCLES cycles, starting in the jump_taken cycle.
- Reset asserted mid-stall or mid-flush forces the reset values immediately. No pending hazard survives reset.
- Forward selects are registered. They are captured when the decode instruction advances into EX and are valid during that instruction's execute cycle. A bubble captures 0.

## Configuration
- PIPE_FORWARDING_EN defined: hazard rule is load-use only.
  - Source matching the EX entry (non-load) gives sel=1.
  - Source matching the MEM entry gives sel=2.
  - Youngest producer wins.
- PIPE_FORWARDING_EN undefined: the full EX/MEM/WB stall rule applies, and fwd_a_sel/fwd_b_sel are tied to 0.

## Structure
- Package pipe_ctrl_pkg holds:
  - REG_ADDR_W default
  - state enum {RUN, STALL, FLUSH}
  - fwd_sel enum {FWD_RF, FWD_MEM, FWD_WB}
  - scoreboard entry struct
- Sub-module pipe_scoreboard holds the three-entry shift and per-source match vectors; the FSM, forward logic and counter stay in the top.

## Test plan
- No forwarding: ADD writes r3, the next instruction reads r3 on src_a -> pc_en=0 for 3 cycles, de_bubble=1 for those 3 cycles, stall_cycles=3.
- PIPE_FORWARDING_EN, same pair -> no stall, fwd_a_sel=1 in the consumer's execute cycle. With one independent instruction between them -> fwd_a_sel=2.
- PIPE_FORWARDING_EN: load writes r5, the next instruction reads r5 on src_b -> 1 stall cycle, then fwd_b_sel=2, stall_cycles=1.
- jump_taken in the same cycle as a hazard -> no stall, fd_flush=de_bubble=1 for 2 cycles, then RUN, stall_cycles unchanged.
- Reset low during the second stall cycle -> all outputs at reset values immediately. After release, a consumer reading r3 proceeds without stall.
- Consumer with id_uses_a=0 and a matching id_src_a -> no stall, fwd_a_sel=0.
